pll_reset_cen_gen: RTL and testbench

// - Consumes the 72 MHz system clock and async `locked` of the core PLL; generates synchronous system reset and fractional clock enables.
// - Sits directly after the PLL wrapper. All core logic (main CPU, sound CPU, video) runs on clk_sys gated by these enables.
// - Holds the core in reset until lock is stable. Re-asserts reset immediately on loss of lock.

---
 rtl/pll_cen_pkg.sv | 24 ++
 rtl/frac_cen.sv | 56 +++++
 rtl/pll_reset_cen_gen.sv | 163 ++++++++++++++++
 tb/tb_pll_reset_cen_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_cen_pkg.sv
// Shared types and defaults for the PLL reset / clock-enable generator.
// Contents: lock-sequencing state enum, default enable ratios, and an
// accumulator width helper used for elaboration-time parameter checks.
package pll_cen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Default enable ratios against the 72 MHz system clock
    localparam int unsigned MAIN_NUM_DFLT = 1;   // 12 MHz
    localparam int unsigned MAIN_DEN_DFLT = 6;
    localparam int unsigned SND_NUM_DFLT  = 7;   // 7 MHz
    localparam int unsigned SND_DEN_DFLT  = 72;
    localparam int unsigned ACC_W_DFLT    = 8;

    // Bits needed to hold acc+NUM, whose worst case is 2*den-1
    function automatic int unsigned acc_width(input int unsigned den);
        return $clog2(2 * den);
    endfunction

endpackage

// File: rtl/frac_cen.sv
// Fractional clock-enable generator: emits NUM single-cycle pulses in every
// window of DEN cycles using a phase accumulator (no long-term drift).
// Ports:
//   clk_sys  system clock
//   rst      synchronous active-high reset
//   clr      synchronous clear of phase and enable (core reset active)
//   hold     freeze phase and suppress the enable
//   cen      registered single-cycle clock enable
module frac_cen #(
    parameter int unsigned NUM = 1,
    parameter int unsigned DEN = 6,
    parameter int unsigned W   = 8
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic cen
);

    localparam logic [W-1:0] NUM_W = W'(NUM);
    localparam logic [W-1:0] DEN_W = W'(DEN);

    logic [W-1:0] acc_q, acc_d, sum;
    logic         cen_q, cen_d;

    // Phase step: wrap by DEN and fire when the accumulator overflows DEN
    always_comb begin
        sum   = acc_q + NUM_W;
        acc_d = acc_q;
        cen_d = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (!hold) begin
            if (sum >= DEN_W) begin
                acc_d = sum - DEN_W;
                cen_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            acc_q <= '0;
            cen_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cen_q <= cen_d;
        end
    end

    assign cen = cen_q;

endmodule

// File: rtl/pll_reset_cen_gen.sv
// PLL lock qualification, core reset generation and fractional clock enables
// for the main CPU and sound sections, all in the clk_sys domain.
// Optional feature macro: PAUSE_CEN_EN adds the pause input, which freezes
// the main-CPU enable phase.
// Ports:
//   clk_sys   72 MHz system clock
//   rst       synchronous active-high reset
//   locked    PLL lock, asynchronous
//   pause     (PAUSE_CEN_EN only) freeze main-CPU enable
//   sys_rst   core reset, synchronous active-high
//   ready     high while running
//   cen_main  main-CPU clock enable
//   cen_snd   sound clock enable
module pll_reset_cen_gen
    import pll_cen_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned RST_CYCLES  = 256,
    parameter int unsigned MAIN_NUM    = MAIN_NUM_DFLT,
    parameter int unsigned MAIN_DEN    = MAIN_DEN_DFLT,
    parameter int unsigned SND_NUM     = SND_NUM_DFLT,
    parameter int unsigned SND_DEN     = SND_DEN_DFLT,
    parameter int unsigned ACC_W       = ACC_W_DFLT
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic locked,
`ifdef PAUSE_CEN_EN
    input  logic pause,
`endif
    output logic sys_rst,
    output logic ready,
    output logic cen_main,
    output logic cen_snd
);

    localparam int unsigned CNT_MAX = (LOCK_STABLE > RST_CYCLES) ? LOCK_STABLE : RST_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Parameter sanity at elaboration
    if (ACC_W < acc_width(MAIN_DEN) || ACC_W < acc_width(SND_DEN)) begin : g_bad_acc_w
        $error("ACC_W too narrow for configured denominators");
    end
    if (MAIN_NUM == 0 || MAIN_NUM > MAIN_DEN || SND_NUM == 0 || SND_NUM > SND_DEN) begin : g_bad_ratio
        $error("enable ratio must satisfy 0 < NUM <= DEN");
    end
    if (LOCK_STABLE < 2 || RST_CYCLES < 1) begin : g_bad_cycles
        $error("LOCK_STABLE must be >= 2 and RST_CYCLES >= 1");
    end

    logic             sync1_q, locked_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             cen_clr, main_hold;

    // Two-flop synchronizer for the asynchronous lock signal
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    // Lock sequencing; any loss of lock falls back to WAIT_LOCK
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!locked_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        // Release follows the registered state; assertion on leaving RUN
        // is taken from the next state so reset rises one cycle earlier.
        sys_rst_d = (state_q != RUN) || (state_d != RUN);
        ready_d   = !sys_rst_d;
    end

    // Clear enables both while reset is pending and while it is held, so no
    // pulse overlaps a sys_rst cycle and phase restarts at release
    assign cen_clr = sys_rst_d | sys_rst_q;

`ifdef PAUSE_CEN_EN
    assign main_hold = pause;
`else
    assign main_hold = 1'b0;
`endif

    frac_cen #(
        .NUM (MAIN_NUM),
        .DEN (MAIN_DEN),
        .W   (ACC_W)
    ) u_cen_main (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (cen_clr),
        .hold    (main_hold),
        .cen     (cen_main)
    );

    frac_cen #(
        .NUM (SND_NUM),
        .DEN (SND_DEN),
        .W   (ACC_W)
    ) u_cen_snd (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (cen_clr),
        .hold    (1'b0),
        .cen     (cen_snd)
    );

    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_pll_reset_cen_gen.sv
// Scoreboard bench for pll_reset_cen_gen: the stimulus schedule fixes the
// expected cycle of every reset edge and enable pulse up front; a negedge
// monitor pops and compares whenever the DUT shows an event.
module tb_pll_reset_cen_gen;

    localparam int QUAL = 1024 + 256 + 3;   // locked rise to sys_rst fall

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    logic locked  = 1'b1;
`ifdef PAUSE_CEN_EN
    logic pause   = 1'b0;
`endif
    logic sys_rst, ready, cen_main, cen_snd;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    typedef struct { int c; logic rs; logic rd; } rst_ev_t;
    typedef struct { int c; logic rs; logic rd; logic cm; logic cs; } lvl_t;

    rst_ev_t q_rst[$];
    lvl_t    q_lvl[$];
    int      q_main[$];
    int      q_snd[$];

    rst_ev_t re;
    lvl_t    le;
    int      pc;
    logic [1:0] prev_sr   = 2'b10;
    logic       prev_snd  = 1'b0;
    int win_lo = 0, win_hi = -1, win_main = 0, win_snd = 0;

    // Schedule (cycle n = period after the n-th rising edge)
    localparam int F1 = 511 + QUAL;        // re-rise after one-cycle glitch
    localparam int L  = F1 + 800;          // lock lost in RUN
    localparam int F2 = L + 10 + QUAL;
    localparam int P  = F2 + 40;           // pause start (feature build)
    localparam int Q0 = F2 + 100;          // rst asserted in RUN
    localparam int Q1 = F2 + 105;          // rst released
    localparam int F3 = Q1 + QUAL;
    localparam int E  = F3 + 100;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    pll_reset_cen_gen dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .locked   (locked),
`ifdef PAUSE_CEN_EN
        .pause    (pause),
`endif
        .sys_rst  (sys_rst),
        .ready    (ready),
        .cen_main (cen_main),
        .cen_snd  (cen_snd)
    );

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push_lvl(input int c, input logic rs, input logic rd);
        lvl_t x;
        x.c = c; x.rs = rs; x.rd = rd; x.cm = 1'b0; x.cs = 1'b0;
        q_lvl.push_back(x);
    endtask

    task automatic push_rst(input int c, input logic rs, input logic rd);
        rst_ev_t x;
        x.c = c; x.rs = rs; x.rd = rd;
        q_rst.push_back(x);
    endtask

    // Pulses after sys_rst falls in cycle f, up to cycle last; p>0 = pause at p
    task automatic push_run(input int f, input int last, input int p);
        int c;
        for (int k = 1; f + 6 * k <= last; k++) begin
            c = f + 6 * k;
            if (p > 0 && c > p) c = c + 13;
            if (c <= last) q_main.push_back(c);
        end
        for (int k = 1; f + k <= last; k++) begin
            if ((7 * k) / 72 != (7 * (k - 1)) / 72) q_snd.push_back(f + k);
        end
    endtask

    // Monitor: compare scheduled levels and every observed output event
    always @(negedge clk_sys) begin
        if (cyc >= 1 && !done) begin
            while (q_lvl.size() > 0 && q_lvl[0].c == cyc) begin
                le = q_lvl.pop_front();
                checks++;
                if ({sys_rst, ready, cen_main, cen_snd} !== {le.rs, le.rd, le.cm, le.cs}) begin
                    failures++;
                    $display("FAIL level cyc=%0d got {rst,rdy,cm,cs}=%b%b%b%b want %b%b%b%b",
                             cyc, sys_rst, ready, cen_main, cen_snd, le.rs, le.rd, le.cm, le.cs);
                end
            end
            if ({sys_rst, ready} !== prev_sr) begin
                checks++;
                if (q_rst.size() == 0) begin
                    failures++;
                    $display("FAIL rst_event unexpected cyc=%0d got {rst,rdy}=%b%b", cyc, sys_rst, ready);
                end else begin
                    re = q_rst.pop_front();
                    if (re.c != cyc || {sys_rst, ready} !== {re.rs, re.rd}) begin
                        failures++;
                        $display("FAIL rst_event got cyc=%0d {rst,rdy}=%b%b want cyc=%0d %b%b",
                                 cyc, sys_rst, ready, re.c, re.rs, re.rd);
                    end
                end
                prev_sr = {sys_rst, ready};
            end
            if (cen_main !== 1'b0) begin
                checks++;
                if (cyc >= win_lo && cyc <= win_hi) win_main++;
                if (q_main.size() == 0) begin
                    failures++;
                    $display("FAIL cen_main unexpected pulse cyc=%0d val=%b", cyc, cen_main);
                end else begin
                    pc = q_main.pop_front();
                    if (pc != cyc) begin
                        failures++;
                        $display("FAIL cen_main pulse got cyc=%0d want cyc=%0d", cyc, pc);
                    end
                end
            end
            if (cen_snd !== 1'b0) begin
                checks++;
                if (cyc >= win_lo && cyc <= win_hi) win_snd++;
                if (prev_snd === 1'b1) begin
                    failures++;
                    $display("FAIL cen_snd back_to_back cyc=%0d", cyc);
                end
                if (q_snd.size() == 0) begin
                    failures++;
                    $display("FAIL cen_snd unexpected pulse cyc=%0d val=%b", cyc, cen_snd);
                end else begin
                    pc = q_snd.pop_front();
                    if (pc != cyc) begin
                        failures++;
                        $display("FAIL cen_snd pulse got cyc=%0d want cyc=%0d", cyc, pc);
                    end
                end
            end
            prev_snd = cen_snd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p_at;
        p_at = 0;
`ifdef PAUSE_CEN_EN
        p_at = P;
`endif
        // Expected levels, ascending by cycle
        for (int c = 2; c <= 10; c += 2) push_lvl(c, 1'b1, 1'b0);
        push_lvl(1293, 1'b1, 1'b0);        // would have released without the glitch
        push_lvl(F1 + 5, 1'b0, 1'b1);
        push_lvl(L + 3, 1'b1, 1'b0);
        push_lvl(Q0 + 1, 1'b1, 1'b0);
        // Expected reset edges
        push_rst(F1, 1'b0, 1'b1);
        push_rst(L + 3, 1'b1, 1'b0);
        push_rst(F2, 1'b0, 1'b1);
        push_rst(Q0 + 1, 1'b1, 1'b0);
        push_rst(F3, 1'b0, 1'b1);
        // Expected enable pulses per RUN interval
        push_run(F1, L + 2, 0);
        push_run(F2, Q0, p_at);
        push_run(F3, E, 0);
        win_lo = F1 + 1;
        win_hi = F1 + 720;

        wait_until(10);  rst    = 1'b0;
        wait_until(510); locked = 1'b0;
        wait_until(511); locked = 1'b1;
        wait_until(L);   locked = 1'b0;
        wait_until(L + 10); locked = 1'b1;
`ifdef PAUSE_CEN_EN
        wait_until(P);      pause = 1'b1;
        wait_until(P + 13); pause = 1'b0;
`endif
        wait_until(Q0);  rst = 1'b1;
        wait_until(Q1);  rst = 1'b0;
        wait_until(E + 1);
        @(posedge clk_sys);
        #2;
        done = 1'b1;

        checks++;
        if (win_main != 120) begin
            failures++;
            $display("FAIL main_window_count got=%0d want=120", win_main);
        end
        checks++;
        if (win_snd != 70) begin
            failures++;
            $display("FAIL snd_window_count got=%0d want=70", win_snd);
        end
        checks++;
        if (q_main.size() != 0) begin
            failures++;
            $display("FAIL cen_main missing pulses left=%0d next_cyc=%0d", q_main.size(), q_main[0]);
        end
        checks++;
        if (q_snd.size() != 0) begin
            failures++;
            $display("FAIL cen_snd missing pulses left=%0d next_cyc=%0d", q_snd.size(), q_snd[0]);
        end
        checks++;
        if (q_rst.size() != 0) begin
            failures++;
            $display("FAIL rst_event missing left=%0d next_cyc=%0d", q_rst.size(), q_rst[0].c);
        end
        checks++;
        if (q_lvl.size() != 0) begin
            failures++;
            $display("FAIL level unchecked left=%0d", q_lvl.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
